// File: rtl/nx_des_word_aligner_pkg.sv
// Shared types and constants for the NX_DES word aligner and its rotate helper.
package nx_des_word_aligner_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCK   = 2'd2
   } align_state_t;

   localparam int OFS_W = 3;
   localparam int CNT_W = 8;

   // Offset advance with wrap from size-1 back to 0.
   function automatic logic [OFS_W-1:0] next_offset(input logic [OFS_W-1:0] ofs,
                                                    input int size);
      return (ofs == OFS_W'(size - 1)) ? '0 : ofs + OFS_W'(1);
   endfunction

endpackage

// File: rtl/nx_word_rotate.sv
// Combinational window select: picks DATA_SIZE contiguous bits out of a
// two-word window {newer, older} starting at bit offset ofs.
module nx_word_rotate
   import nx_des_word_aligner_pkg::*;
#(
   parameter int DATA_SIZE = 5
) (
   input  logic [2*DATA_SIZE-1:0] window,
   input  logic [OFS_W-1:0]       ofs,
   output logic [DATA_SIZE-1:0]   word
);

   // An out-of-range offset falls back to the newer word.
   always_comb begin
      word = window[2*DATA_SIZE-1:DATA_SIZE];
      for (int k = 0; k < DATA_SIZE; k++) begin
         if (ofs == OFS_W'(k)) begin
            word = window[k +: DATA_SIZE];
         end
      end
   end

endmodule

// File: rtl/nx_des_word_aligner.sv
// Word aligner behind NX_DES: searches all rotations for the training word
// during link training, locks on, then delivers framed words with status.
module nx_des_word_aligner
   import nx_des_word_aligner_pkg::*;
#(
   parameter int                   DATA_SIZE     = 5,
   parameter logic [DATA_SIZE-1:0] TRAIN_PATTERN = 5'b00111,
   parameter int                   LOCK_COUNT    = 16,
   parameter int                   LOSS_COUNT    = 4
) (
   input  logic                 CK,
   input  logic                 R,
   input  logic [DATA_SIZE-1:0] I,
   input  logic                 TRN,
   output logic [DATA_SIZE-1:0] O,
   output logic                 OV,
   output logic                 LOCKED,
   output logic [OFS_W-1:0]     OFS,
   output logic                 SLIP
);

   logic [DATA_SIZE-1:0] iq;
   logic [DATA_SIZE-1:0] prev;
   logic                 seen_edge;
   logic                 primed;
   align_state_t         state;
   align_state_t         next_state;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     next_cnt;
   logic [OFS_W-1:0]     next_ofs;
   logic                 next_slip;
   logic [DATA_SIZE-1:0] cand;
   logic                 match;

   nx_word_rotate #(
      .DATA_SIZE(DATA_SIZE)
   ) u_rotate (
      .window(({iq, prev})),
      .ofs   (OFS),
      .word  (cand)
   );

   // Until both iq and prev hold received words the window is meaningless.
   assign match = primed && (cand == TRAIN_PATTERN);

   always_ff @(posedge CK or posedge R) begin
      if (R) begin
         iq        <= '0;
         prev      <= '0;
         seen_edge <= 1'b0;
         primed    <= 1'b0;
         state     <= SEARCH;
         cnt       <= '0;
         OFS       <= '0;
         SLIP      <= 1'b0;
         O         <= '0;
         OV        <= 1'b0;
         LOCKED    <= 1'b0;
      end else begin
         iq        <= I;
         prev      <= iq;
         seen_edge <= 1'b1;
         primed    <= seen_edge;
         state     <= next_state;
         cnt       <= next_cnt;
         OFS       <= next_ofs;
         SLIP      <= next_slip;
         O         <= cand;
         OV        <= (state == LOCK);
         LOCKED    <= (state == LOCK);
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_ofs   = OFS;
      next_slip  = 1'b0;
      case (state)
         SEARCH: begin
            if (TRN && primed) begin
               if (match) begin
                  next_state = VERIFY;
                  next_cnt   = CNT_W'(1);
               end else begin
                  next_ofs  = next_offset(OFS, DATA_SIZE);
                  next_slip = 1'b1;
               end
            end
         end
         // LOCK_COUNT is compared before incrementing, so lock needs one extra match.
         VERIFY: begin
            if (TRN) begin
               if (match) begin
                  if (cnt == CNT_W'(LOCK_COUNT)) begin
                     next_state = LOCK;
                     next_cnt   = '0;
                  end else begin
                     next_cnt = cnt + CNT_W'(1);
                  end
               end else begin
                  next_state = SEARCH;
                  next_ofs   = next_offset(OFS, DATA_SIZE);
                  next_slip  = 1'b1;
                  next_cnt   = '0;
               end
            end
         end
         LOCK: begin
            if (!TRN || match) begin
               next_cnt = '0;
            end else if ((cnt + CNT_W'(1)) == CNT_W'(LOSS_COUNT)) begin
               next_state = SEARCH;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         default: begin
            next_state = SEARCH;
            next_cnt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_nx_des_word_aligner.sv
// Self-checking bench for nx_des_word_aligner: a serial-bit behavioural model
// checked every cycle, plus directed scenarios with hand-computed results.
module tb_nx_des_word_aligner;

   localparam int         DS   = 5;
   localparam logic [4:0] PAT  = 5'b00111;
   localparam int         LC   = 16;
   localparam int         LS   = 4;
   // Repeated 00111 stream with the true framing offset at 3.
   localparam logic [4:0] GOOD = 5'b11001;
   // Flips only the bits that land in the window while the word sits in iq.
   localparam logic [4:0] BAD  = 5'b11110;

   logic       CK;
   logic       R;
   logic [4:0] I;
   logic       TRN;
   logic [4:0] O;
   logic       OV;
   logic       LOCKED;
   logic [2:0] OFS;
   logic       SLIP;

   int checks;
   int errors;

   logic [4:0] m_iq, m_prev, m_o;
   int         m_edges, m_mode, m_ofs, m_cnt;
   logic       m_lk, m_slip;

   int call_idx;
   int slip_count;
   int lock_at;

   nx_des_word_aligner #(
      .DATA_SIZE    (DS),
      .TRAIN_PATTERN(PAT),
      .LOCK_COUNT   (LC),
      .LOSS_COUNT   (LS)
   ) dut (
      .CK    (CK),
      .R     (R),
      .I     (I),
      .TRN   (TRN),
      .O     (O),
      .OV    (OV),
      .LOCKED(LOCKED),
      .OFS   (OFS),
      .SLIP  (SLIP)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic cmp(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at call %0d: actual=%0d expected=%0d", name, call_idx, actual, expected);
      end
   endtask

   task automatic modelReset();
      m_iq = '0; m_prev = '0; m_o = '0;
      m_edges = 0; m_mode = 0; m_ofs = 0; m_cnt = 0;
      m_lk = 1'b0; m_slip = 1'b0;
   endtask

   // One clock edge of the aligner seen as a serial bit stream: the candidate
   // is DS consecutive received bits starting OFS bits into the older word.
   task automatic modelStep(input logic [4:0] w, input logic t);
      logic [4:0] c;
      bit         m;
      for (int j = 0; j < DS; j++) begin
         int k;
         k = m_ofs + j;
         c[j] = (k < DS) ? m_prev[k] : m_iq[k - DS];
      end
      m = (m_edges >= 2) && (c == PAT);
      m_o    = c;
      m_lk   = (m_mode == 2);
      m_slip = 1'b0;
      if (t) begin
         if (m_mode == 0) begin
            if (m_edges >= 2) begin
               if (m) begin
                  m_mode = 1; m_cnt = 1;
               end else begin
                  m_ofs = (m_ofs + 1) % DS; m_slip = 1'b1;
               end
            end
         end else if (m_mode == 1) begin
            if (m) begin
               if (m_cnt == LC) begin
                  m_mode = 2; m_cnt = 0;
               end else begin
                  m_cnt++;
               end
            end else begin
               m_mode = 0; m_ofs = (m_ofs + 1) % DS; m_slip = 1'b1; m_cnt = 0;
            end
         end else begin
            if (m) begin
               m_cnt = 0;
            end else begin
               m_cnt++;
               if (m_cnt == LS) begin
                  m_mode = 0; m_cnt = 0;
               end
            end
         end
      end else if (m_mode == 2) begin
         m_cnt = 0;
      end
      m_prev = m_iq;
      m_iq   = w;
      m_edges++;
   endtask

   task automatic checkOutput();
      cmp("O", int'(O), int'(m_o));
      cmp("OV", int'(OV), int'(m_lk));
      cmp("LOCKED", int'(LOCKED), int'(m_lk));
      cmp("OFS", int'(OFS), m_ofs);
      cmp("SLIP", int'(SLIP), int'(m_slip));
   endtask

   // Called at a negedge; drives one word, steps the model on the edge and
   // compares on the following negedge.
   task automatic applyStimulus(input logic [4:0] w, input logic t);
      I   = w;
      TRN = t;
      @(posedge CK);
      modelStep(w, t);
      @(negedge CK);
      call_idx++;
      if (SLIP) slip_count++;
      if (LOCKED && lock_at < 0) lock_at = call_idx;
      checkOutput();
   endtask

   task automatic checkAllZero(input string tag);
      cmp({tag, " O"}, int'(O), 0);
      cmp({tag, " OV"}, int'(OV), 0);
      cmp({tag, " LOCKED"}, int'(LOCKED), 0);
      cmp({tag, " OFS"}, int'(OFS), 0);
      cmp({tag, " SLIP"}, int'(SLIP), 0);
   endtask

   task automatic holdReset();
      R = 1'b1;
      modelReset();
      repeat (2) @(negedge CK);
      checkAllZero("reset");
      R = 1'b0;
      call_idx = 0; slip_count = 0; lock_at = -1;
   endtask

   task automatic trainFromReset(input string tag);
      for (int n = 0; n < 30; n++) applyStimulus(GOOD, 1'b1);
      cmp({tag, " slip pulses"}, slip_count, 3);
      cmp({tag, " lock call"}, lock_at, 23);
      cmp({tag, " OFS locked"}, int'(OFS), 3);
      cmp({tag, " O framed"}, int'(O), int'(PAT));
   endtask

   initial begin
      logic [4:0] w1, w2;
      logic [9:0] win;
      int         seq[$];
      checks = 0; errors = 0;
      I = '0; TRN = 1'b0; R = 1'b1;
      call_idx = 0; slip_count = 0; lock_at = -1;

      $display("[TB] scenario 1: cold training, true offset 3");
      holdReset();
      trainFromReset("cold");

      $display("[TB] scenario 2: isolated corruptions while locked");
      applyStimulus(BAD, 1'b1);
      applyStimulus(GOOD, 1'b1);
      for (int n = 0; n < 3; n++) applyStimulus(BAD, 1'b1);
      for (int n = 0; n < 3; n++) applyStimulus(GOOD, 1'b1);
      cmp("cnt cleared LOCKED", int'(LOCKED), 1);

      $display("[TB] scenario 3: loss of lock and relock");
      slip_count = 0;
      for (int n = 0; n < 4; n++) applyStimulus(BAD, 1'b1);
      applyStimulus(GOOD, 1'b1);
      applyStimulus(GOOD, 1'b1);
      cmp("loss LOCKED", int'(LOCKED), 0);
      cmp("loss OFS", int'(OFS), 3);
      for (int n = 0; n < 20; n++) applyStimulus(GOOD, 1'b1);
      cmp("relock LOCKED", int'(LOCKED), 1);
      cmp("relock OFS", int'(OFS), 3);
      cmp("relock slips", slip_count, 0);

      $display("[TB] scenario 4: data mode");
      w1 = GOOD; w2 = GOOD;
      for (int n = 0; n < 20; n++) begin
         logic [4:0] r;
         r = 5'($urandom_range(0, 31));
         applyStimulus(r, 1'b0);
         win = {w1, w2};
         win = win >> 3;
         cmp("data O reframed", int'(O), int'(win[4:0]));
         w2 = w1; w1 = r;
      end
      cmp("data LOCKED", int'(LOCKED), 1);

      $display("[TB] scenario 5: mismatch in VERIFY at cnt 8");
      holdReset();
      for (int n = 0; n < 12; n++) applyStimulus(GOOD, 1'b1);
      applyStimulus(BAD, 1'b1);
      slip_count = 0;
      applyStimulus(GOOD, 1'b1);
      cmp("verify-miss OFS", int'(OFS), 4);
      cmp("verify-miss SLIP", int'(SLIP), 1);
      for (int n = 0; n < 26; n++) begin
         applyStimulus(GOOD, 1'b1);
         if (SLIP) seq.push_back(int'(OFS));
      end
      cmp("wrap slip count", seq.size(), 4);
      for (int n = 0; n < 4 && n < seq.size(); n++) cmp("wrap OFS order", seq[n], n);
      cmp("wrap LOCKED", int'(LOCKED), 1);
      cmp("wrap OFS", int'(OFS), 3);

      $display("[TB] scenario 6: asynchronous reset while locked");
      #2 R = 1'b1;
      #1 checkAllZero("async");
      modelReset();
      @(negedge CK);
      R = 1'b0;
      call_idx = 0; slip_count = 0; lock_at = -1;
      trainFromReset("after-async");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
